// File: rtl/pool_sched.sv
// Raster-order tile sequencer feeding the 2x2 max-pool datapath, with in-flight output metering.
// Optional RUN stall counter output perf_stall is enabled by defining POOL_SCHED_PERF_EN.
module pool_sched #(
  parameter int DW           = 8,
  parameter int DN           = 6,
  parameter int AW           = 12,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       cfg_width,
  input  logic [5:0]       cfg_height,
  input  logic             cfg_pool_en,
  input  logic [AW-1:0]    cfg_base,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [DN*DW-1:0] rd_data,
  output logic [DN*DW-1:0] pool_data,
  output logic             pool_valid,
  output logic [5:0]       pool_width,
  output logic             pool_en,
  input  logic             pool_out_valid,
  input  logic             pool_out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef POOL_SCHED_PERF_EN
  ,
  output logic [15:0]      perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t        state;
  logic [5:0]    w_q;
  logic [5:0]    h_q;
  logic          pool_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] addr;
  logic [5:0]    col;
  logic [5:0]    row;
  logic [3:0]    inflight;

  logic       dec;
  logic [3:0] infl_dn;
  logic       prod;
  logic       issue;
  logic       last;
  logic       legal;

  // Retire before issue so a same-cycle accept frees a slot.
  assign dec     = pool_out_valid & pool_out_ready;
  assign infl_dn = (dec && inflight != 4'd0) ? inflight - 4'd1 : inflight;
  assign prod    = pool_q ? (row[0] & col[0]) : 1'b1;
  assign issue   = (state == S_RUN) && (32'(infl_dn) < MAX_INFLIGHT);
  assign last    = (row == h_q - 6'd1) && (col == w_q - 6'd1);
  assign legal   = (w_q != 6'd0) && (h_q != 6'd0) &&
                   !(pool_q && (w_q[0] | h_q[0]));

  // SRAM data arrives the cycle after the read strobe.
  assign pool_data = pool_valid ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      pool_q     <= 1'b0;
      base_q     <= '0;
      addr       <= '0;
      col        <= '0;
      row        <= '0;
      inflight   <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      pool_valid <= 1'b0;
      pool_width <= '0;
      pool_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef POOL_SCHED_PERF_EN
      perf_stall <= '0;
`endif
    end else begin
      rd_en      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pool_valid <= rd_en;
      inflight   <= infl_dn + {3'b000, issue & prod};
      unique case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            w_q    <= cfg_width;
            h_q    <= cfg_height;
            pool_q <= cfg_pool_en;
            base_q <= cfg_base;
            col    <= '0;
            row    <= '0;
            busy   <= 1'b1;
            state  <= S_CHECK;
`ifdef POOL_SCHED_PERF_EN
            perf_stall <= '0;
`endif
          end
        end
        S_CHECK: begin
          if (legal) begin
            addr       <= base_q;
            pool_width <= w_q;
            pool_en    <= pool_q;
            state      <= S_RUN;
          end else begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (issue) begin
            rd_en   <= 1'b1;
            rd_addr <= addr;
            addr    <= addr + 1'b1;
            if (last) begin
              state <= S_DRAIN;
            end else if (col == w_q - 6'd1) begin
              col <= '0;
              row <= row + 6'd1;
            end else begin
              col <= col + 6'd1;
            end
          end
`ifdef POOL_SCHED_PERF_EN
          else if (perf_stall != 16'hFFFF) begin
            perf_stall <= perf_stall + 16'd1;
          end
`endif
        end
        S_DRAIN: begin
          if (!pool_valid && infl_dn == 4'd0) begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pool_sched.md
Name: pool_sched

Overview:
- Sequencer for the 2x2 max-pool datapath. On start it walks one feature-map tile in a line buffer SRAM in raster order.
- It drives the datapath input beat stream: data, valid, row width and pool enable.
- The datapath output has a ready, but its input has none. This block therefore meters issue with an in-flight output counter, so the datapath's output register never has to drop a result.
- Sits between the tile SRAM and the pool datapath; reports done/error to the layer controller.

Parameters:
- DW, 8, element width in bits
- DN, 6, elements per beat (channel lanes)
- AW, 12, SRAM address width
- MAX_INFLIGHT, 2, maximum datapath outputs issued but not yet accepted downstream (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; ignored unless in IDLE
- cfg_width  in  6  columns per row (beats), 1..63
- cfg_height  in  6  rows, 1..63
- cfg_pool_en  in  1  1 = 2x2 max pool, 0 = bypass
- cfg_base  in  AW  SRAM address of pixel (0,0)
- rd_en  out  1  SRAM read strobe
- rd_addr  out  AW  SRAM read address
- rd_data  in  DN*DW  SRAM data, valid exactly 1 cycle after rd_en
- pool_data  out  DN*DW  datapath input beat
- pool_valid  out  1  datapath input valid
- pool_width  out  6  latched cfg_width
- pool_en  out  1  latched cfg_pool_en
- pool_out_valid  in  1  datapath output valid (observed)
- pool_out_ready  in  1  downstream ready (observed)
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when tile complete
- err  out  1  one-cycle pulse on illegal configuration

Behaviour:
- Reset values: rd_en=0, rd_addr=0, pool_valid=0, pool_data=0, pool_width=0, pool_en=0, busy=0, done=0, err=0. State goes to IDLE and all counters clear.
- Reset mid-tile aborts the tile. No done is pulsed.
- FSM states: IDLE, CHECK, RUN, DRAIN, FIN.
- IDLE: on start, latch all cfg_* values and go to CHECK.
- CHECK (1 cycle): the configuration is illegal if width==0, or height==0, or pool_en=1 with odd width or odd height.
  - Illegal: pulse err, go to IDLE. No read is issued.
  - Legal: go to RUN.
- RUN: counters col (0..W-1) and row (0..H-1) advance in raster order.
  - rd_addr = cfg_base + row*W + col, formed incrementally (+1 per issue). It wraps modulo 2^AW.
  - The issue condition is inflight_next < MAX_INFLIGHT.
  - rd_en=1 in an issue cycle. One cycle later, pool_valid=1 and pool_data=rd_data.
- Producing beat:
  - Bypass: every beat is producing.
  - Pool: a beat is producing when row is odd and col is odd.
- inflight counter:
  - +1 when a producing beat issues.
  - -1 on pool_out_valid & pool_out_ready.
  - Both in the same cycle: unchanged.
  - Decrement at 0 is a protocol violation; the counter saturates at 0.
- After the last beat (row=H-1, col=W-1) issues, go to DRAIN.
- DRAIN: wait until the final pool_valid has been presented and inflight==0, then go to FIN.
- FIN: pulse done for 1 cycle, go to IDLE. busy drops in that same IDLE cycle.
- Expected outputs:
  - Pool: (W/2)*(H/2).
  - Bypass: W*H.
- Latency: start to first rd_en = 2 cycles; rd_en to pool_valid = 1 cycle.
- pool_width and pool_en hold their latched values until the next legal start, including through IDLE.

Optional Feature:
- Macro: POOL_SCHED_PERF_EN.
- Defined: adds output perf_stall  out  16, which counts RUN cycles where issue was blocked by the inflight limit.
  - Saturates at 0xFFFF.
  - Clears on start acceptance.
  - Holds its value after done.
- Undefined: no port and no counter logic.

Test Plan:
- Bypass, W=4, H=2, base=0x010, pool_out_ready held 1 -> rd_addr 0x010..0x017, 8 pool_valid beats matching SRAM contents, done 1 cycle after the last output is accepted.
- Pool, W=4, H=4, ready=1 -> 16 beats issued, exactly 4 outputs counted, done pulse, busy low the following cycle.
- Pool, W=4, H=4, MAX_INFLIGHT=2, pool_out_ready=0 for 30 cycles -> issue halts after 2 producing beats; resumes within 1 cycle of ready going high; with PERF_EN, perf_stall equals the blocked cycles.
- cfg_width=5, pool_en=1 -> err pulse 1 cycle after start, rd_en never asserted, back to IDLE; width=0 gives the same response.
- rst asserted mid-RUN (row=1, col=2) -> all outputs reset next cycle; a new start then runs a full tile correctly.
- base=0xFFE, W=4, H=1, bypass -> rd_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
